lc3b_cc_unit: RTL

Condition-code producer for the LC-3b datapath: classifies each CC-writing result word as negative, zero or positive and holds the architectural `nzp` register that the branch comparator reads. It also tracks in-flight CC-writing instructions through a small pending counter. `cc_ready` tells branch logic when `nzp_cc` is current, and `issue_ready` throttles issue once the tracker is full. It sits between the writeback stage (producer side) and the branch-enable comparator (consumer side).

---
 rtl/lc3b_cc_unit_if.sv | 33 +++
 rtl/lc3b_cc_unit.sv | 105 ++++++++++
 2 files changed

// File: rtl/lc3b_cc_unit_if.sv
// lc3b_cc_unit_if: bundles the condition-code unit's producer and consumer
// signals.
//   slave  modport - seen by lc3b_cc_unit
//   master modport - seen by the issue/writeback/branch side
// Signals:
//   issue_valid   : a CC-writing instruction requests issue
//   issue_ready   : the pending tracker can accept an issue
//   wb_valid      : a CC-writing result is written back
//   wb_data       : result word being written back
//   flush         : squash all in-flight CC writers
//   nzp_cc        : architectural one-hot {n,z,p} condition codes
//   cc_ready      : no CC writer pending, so nzp_cc is final
//   err_underflow : sticky writeback-without-pending error
interface lc3b_cc_unit_if;
    logic        issue_valid;
    logic        issue_ready;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        flush;
    logic [2:0]  nzp_cc;
    logic        cc_ready;
    logic        err_underflow;

    modport slave (
        input  issue_valid, wb_valid, wb_data, flush,
        output issue_ready, nzp_cc, cc_ready, err_underflow
    );

    modport master (
        output issue_valid, wb_valid, wb_data, flush,
        input  issue_ready, nzp_cc, cc_ready, err_underflow
    );
endinterface

// File: rtl/lc3b_cc_unit.sv
// lc3b_cc_unit: LC-3b condition-code producer.
// Classifies each accepted writeback word as n/z/p, holds the architectural
// nzp register and counts in-flight CC-writing instructions so branch logic
// knows when the codes are final.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset
//   io_cc  : lc3b_cc_unit_if.slave (issue / writeback / flush / outputs)
// Parameter:
//   MAX_PENDING : maximum in-flight CC writers, 1..7
module lc3b_cc_unit #(
    parameter int MAX_PENDING = 3
) (
    input  logic           i_clk,
    input  logic           i_rst,
    lc3b_cc_unit_if.slave  io_cc
);

    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] P_MAX = PW'(MAX_PENDING);
    localparam logic [PW-1:0] P_ONE = PW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_pend;
    logic [PW-1:0] w_pend_next;
    logic [2:0]    r_nzp;
    logic [2:0]    w_class;
    logic          r_err;
    logic          w_issue_ready;
    logic          w_acc;
    logic          w_wba;
    logic          w_uflow;

    // Outputs decode registered state only; no input reaches them
    // combinationally, so a wba in FULL frees a slot one cycle later.
    assign w_issue_ready = (r_pend != P_MAX);

    assign w_acc   = io_cc.issue_valid & w_issue_ready & ~io_cc.flush;
    assign w_wba   = io_cc.wb_valid & (r_pend != '0);
    assign w_uflow = io_cc.wb_valid & (r_pend == '0);

    // Exactly one of n/z/p is produced for any word.
    always_comb begin
        w_class = 3'b001;
        if (io_cc.wb_data[15])
            w_class = 3'b100;
        else if (io_cc.wb_data == 16'h0000)
            w_class = 3'b010;
    end

    // Next-state / next-count. The state mirrors the counter range
    // (0, between, MAX) so it is updated alongside it. acc and wba
    // together cancel and leave both untouched.
    always_comb begin
        w_pend_next  = r_pend;
        w_state_next = r_state;
        if (io_cc.flush) begin
            w_pend_next  = '0;
            w_state_next = S_IDLE;
        end else if (w_acc && !w_wba) begin
            w_pend_next  = r_pend + P_ONE;
            w_state_next = (r_pend == P_MAX - P_ONE) ? S_FULL : S_BUSY;
        end else if (w_wba && !w_acc) begin
            w_pend_next  = r_pend - P_ONE;
            w_state_next = (r_pend == P_ONE) ? S_IDLE : S_BUSY;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
        end
    end

    // A wba in a flush cycle still loads the codes: that instruction is
    // older than the flush point.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_nzp <= 3'b010;
            r_err <= 1'b0;
        end else begin
            if (w_wba)
                r_nzp <= w_class;
            if (w_uflow)
                r_err <= 1'b1;
        end
    end

    assign io_cc.issue_ready   = w_issue_ready;
    assign io_cc.cc_ready      = (r_state == S_IDLE);
    assign io_cc.nzp_cc        = r_nzp;
    assign io_cc.err_underflow = r_err;

endmodule
